hamming_byte_decoder: RTL and testbench

//  Consumes 7-bit Hamming(7,4) codewords from the UART receiver (data_out/valid_out) and

---
 rtl/hamming_pkg.sv | 42 ++++
 rtl/hamming_byte_decoder_if.sv | 20 ++
 rtl/byte_fifo.sv | 58 +++++
 rtl/hamming_byte_decoder.sv | 110 +++++++++++
 tb/tb_hamming_byte_decoder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_pkg.sv
// Shared widths, codeword bit positions, pairing states and the Hamming(7,4) corrector.
package hamming_pkg;

   localparam int unsigned CODE_W = 7;
   localparam int unsigned NIB_W  = 4;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned SYN_W  = 3;

   // Bit index of each Hamming position inside code_in (position k+1 lives at bit k).
   localparam int unsigned POS_P1 = 0;
   localparam int unsigned POS_P2 = 1;
   localparam int unsigned POS_D1 = 2;
   localparam int unsigned POS_P3 = 3;
   localparam int unsigned POS_D2 = 4;
   localparam int unsigned POS_D3 = 5;
   localparam int unsigned POS_D4 = 6;

   // Nibble pairing FSM states.
   localparam logic ST_LOW  = 1'b0;
   localparam logic ST_HIGH = 1'b1;

   typedef struct packed {
      logic [SYN_W-1:0] syn;
      logic [NIB_W-1:0] nibble;
   } dec_t;

   // Syndrome decode; a nonzero syndrome names the (1-based) position to invert.
   function automatic dec_t hamming74_correct(input logic [CODE_W-1:0] code);
      dec_t              r;
      logic [CODE_W-1:0] fixed;
      r.syn[0] = code[POS_P1] ^ code[POS_D1] ^ code[POS_D2] ^ code[POS_D4];
      r.syn[1] = code[POS_P2] ^ code[POS_D1] ^ code[POS_D3] ^ code[POS_D4];
      r.syn[2] = code[POS_P3] ^ code[POS_D2] ^ code[POS_D3] ^ code[POS_D4];
      fixed    = code;
      if (r.syn != '0) begin
         fixed = code ^ (CODE_W'(1) << (r.syn - SYN_W'(1)));
      end
      r.nibble = {fixed[POS_D4], fixed[POS_D3], fixed[POS_D2], fixed[POS_D1]};
      return r;
   endfunction

endpackage

// File: rtl/hamming_byte_decoder_if.sv
// Codeword input strobe and valid/ready byte output of the decoder.
interface hamming_byte_decoder_if;
   import hamming_pkg::*;

   logic [CODE_W-1:0] code_in;
   logic              code_valid;
   logic [BYTE_W-1:0] byte_out;
   logic              byte_valid;
   logic              byte_ready;

   modport master (
      output code_in, code_valid, byte_ready,
      input  byte_out, byte_valid
   );

   modport slave (
      input  code_in, code_valid, byte_ready,
      output byte_out, byte_valid
   );
endinterface

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO; a push while full only lands when a pop frees the slot in the same cycle.
module byte_fifo
   import hamming_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              push,
   input  logic [BYTE_W-1:0] din,
   input  logic              pop,
   output logic [BYTE_W-1:0] dout,
   output logic              empty,
   output logic              full
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned LVL_W = $clog2(DEPTH + 1);

   logic [BYTE_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  count;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign full    = (count == LVL_W'(DEPTH));
   assign do_pop  = ena && pop && !empty;
   assign do_push = ena && push && (!full || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   // Storage array; contents are don't-care until the count covers them.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; count separates full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + LVL_W'(1);
            2'b01:   count <= count - LVL_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/hamming_byte_decoder.sv
// Hamming(7,4) corrector, nibble-to-byte pairing and byte FIFO between UART RX and byte consumer.
module hamming_byte_decoder
   import hamming_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ena,
   input  logic                   sync_clr,
   hamming_byte_decoder_if.slave  bus,
   output logic [CNT_W-1:0]       corrected_cnt,
   output logic                   overflow,
   output logic                   nibble_phase
);

   dec_t             dec_c;
   logic [NIB_W-1:0] nib_q;
   logic             strobe_q;
   logic [NIB_W-1:0] lo_q;
   logic             state_q;
   logic             state_d;
   logic             push_c;
   logic             lo_load_c;
   logic             pop_c;
   logic             fifo_empty;
   logic             fifo_full;

   assign dec_c        = hamming74_correct(bus.code_in);
   assign pop_c        = bus.byte_ready && !fifo_empty;
   assign nibble_phase = state_q;
   assign bus.byte_valid = !fifo_empty;

   // Stage 1: capture the corrected nibble and a one-cycle strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nib_q    <= '0;
         strobe_q <= 1'b0;
      end else if (ena) begin
         strobe_q <= bus.code_valid;
         if (bus.code_valid) nib_q <= dec_c.nibble;
      end
   end

   // Saturating count of codewords that needed correction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corrected_cnt <= '0;
      end else if (ena && bus.code_valid && (dec_c.syn != '0) && (corrected_cnt != '1)) begin
         corrected_cnt <= corrected_cnt + CNT_W'(1);
      end
   end

   // Pairing FSM state register and held low nibble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_LOW;
         lo_q    <= '0;
      end else if (ena) begin
         state_q <= state_d;
         if (lo_load_c) lo_q <= nib_q;
      end
   end

   // Pairing FSM next state; sync_clr realigns to the low nibble and wins over a strobe.
   always_comb begin
      state_d = state_q;
      if (sync_clr) begin
         state_d = ST_LOW;
      end else if (strobe_q) begin
         state_d = (state_q == ST_LOW) ? ST_HIGH : ST_LOW;
      end
   end

   // Pairing FSM outputs: latch the low nibble or push the completed byte.
   always_comb begin
      push_c    = 1'b0;
      lo_load_c = 1'b0;
      if (!sync_clr && strobe_q) begin
         if (state_q == ST_LOW) lo_load_c = 1'b1;
         else                   push_c    = 1'b1;
      end
   end

   // Sticky drop flag, cleared only by sync_clr or reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (ena) begin
         if (sync_clr)                               overflow <= 1'b0;
         else if (push_c && fifo_full && !pop_c)     overflow <= 1'b1;
      end
   end

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .push  (push_c),
      .din   ({nib_q, lo_q}),
      .pop   (bus.byte_ready),
      .dout  (bus.byte_out),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_hamming_byte_decoder.sv
// Directed bench for hamming_byte_decoder with hand-computed expected bytes and counts.
module tb_hamming_byte_decoder;
   import hamming_pkg::*;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       ena      = 1'b0;
   logic       sync_clr = 1'b0;
   logic [7:0] corrected_cnt;
   logic       overflow;
   logic       nibble_phase;

   int unsigned tests    = 0;
   int unsigned failures = 0;
   int unsigned exp_cnt  = 0;

   hamming_byte_decoder_if bus();

   hamming_byte_decoder #(
      .FIFO_DEPTH (4),
      .CNT_W      (8)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ena           (ena),
      .sync_clr      (sync_clr),
      .bus           (bus.slave),
      .corrected_cnt (corrected_cnt),
      .overflow      (overflow),
      .nibble_phase  (nibble_phase)
   );

   always #5 clk = ~clk;

   // Reference encoder: code = {d4,d3,d2,p3,d1,p2,p1}.
   function automatic logic [6:0] enc(input logic [3:0] n);
      logic p1, p2, p3;
      p1 = n[0] ^ n[1] ^ n[3];
      p2 = n[0] ^ n[2] ^ n[3];
      p3 = n[1] ^ n[2] ^ n[3];
      return {n[3], n[2], n[1], p3, n[0], p2, p1};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; drives one strobe cycle and returns at the next negedge.
   task automatic strobe(input logic [6:0] c);
      bus.code_in    = c;
      bus.code_valid = 1'b1;
      @(negedge clk);
      bus.code_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pop_one();
      bus.byte_ready = 1'b1;
      @(negedge clk);
      bus.byte_ready = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      strobe(enc(b[3:0]));
      strobe(enc(b[7:4]));
   endtask

   task automatic expect_byte(input string tag, input logic [7:0] b);
      check({tag, "_valid"}, 32'(bus.byte_valid), 32'd1);
      check(tag, 32'(bus.byte_out), 32'(b));
      pop_one();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] n;
      logic [3:0] nn;
      bus.code_in    = '0;
      bus.code_valid = 1'b0;
      bus.byte_ready = 1'b0;

      // Reset state
      #1;
      check("rst_byte_out", 32'(bus.byte_out), 32'h0);
      check("rst_valid",    32'(bus.byte_valid), 32'd0);
      check("rst_cnt",      32'(corrected_cnt), 32'd0);
      check("rst_ovf",      32'(overflow), 32'd0);
      check("rst_phase",    32'(nibble_phase), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ena   = 1'b1;
      idle(1);

      // 1: clean pair, latency
      strobe(7'h2D);
      strobe(7'h52);
      check("t1_valid_early", 32'(bus.byte_valid), 32'd0);
      idle(1);
      check("t1_cnt", 32'(corrected_cnt), 32'd0);
      expect_byte("t1_byte", 8'hA5);
      check("t1_empty", 32'(bus.byte_valid), 32'd0);

      // 2: single-bit error and full sweep
      strobe(7'h3D);
      strobe(7'h52);
      exp_cnt = 1;
      idle(1);
      expect_byte("t2_byte", 8'hA5);
      check("t2_cnt", 32'(corrected_cnt), 32'(exp_cnt));
      for (int k = 0; k < 7; k++) begin
         for (int i = 0; i < 16; i++) begin
            n  = 4'(i);
            nn = ~n;
            strobe(enc(n) ^ (7'(1) << k));
            strobe(enc(nn));
            exp_cnt++;
            idle(1);
            check($sformatf("sweep_k%0d_n%0d", k, i), 32'(bus.byte_out), 32'({nn, n}));
            pop_one();
         end
      end
      check("t2_sweep_cnt", 32'(corrected_cnt), 32'(exp_cnt));

      // 3: overflow with consumer stalled
      for (int i = 0; i < 5; i++) send_byte(8'hA5);
      idle(2);
      check("t3_ovf", 32'(overflow), 32'd1);
      check("t3_phase", 32'(nibble_phase), 32'd0);
      for (int i = 0; i < 4; i++) expect_byte($sformatf("t3_drain%0d", i), 8'hA5);
      check("t3_empty", 32'(bus.byte_valid), 32'd0);
      check("t3_byte_zero", 32'(bus.byte_out), 32'h0);
      sync_clr = 1'b1;
      @(negedge clk);
      sync_clr = 1'b0;
      check("t3_ovf_clr", 32'(overflow), 32'd0);

      // 4: push into full FIFO coinciding with a pop
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      send_byte(8'h44);
      idle(2);
      send_byte(8'h55);
      bus.byte_ready = 1'b1;
      @(negedge clk);
      bus.byte_ready = 1'b0;
      idle(1);
      check("t4_ovf", 32'(overflow), 32'd0);
      expect_byte("t4_b22", 8'h22);
      expect_byte("t4_b33", 8'h33);
      expect_byte("t4_b44", 8'h44);
      expect_byte("t4_b55", 8'h55);
      check("t4_empty", 32'(bus.byte_valid), 32'd0);

      // 5: phase realignment via sync_clr
      strobe(7'h2D);
      idle(2);
      check("t5_phase_hi", 32'(nibble_phase), 32'd1);
      sync_clr = 1'b1;
      @(negedge clk);
      sync_clr = 1'b0;
      check("t5_phase_lo", 32'(nibble_phase), 32'd0);
      strobe(7'h52);
      strobe(7'h2D);
      idle(1);
      expect_byte("t5_byte", 8'h5A);

      // 5b: ena low freezes everything
      send_byte(8'h3C);
      idle(2);
      strobe(enc(4'h7));
      idle(2);
      ena            = 1'b0;
      bus.byte_ready = 1'b1;
      sync_clr       = 1'b1;
      for (int i = 0; i < 6; i++) strobe(7'h3D);
      check("t5_ena_phase", 32'(nibble_phase), 32'd1);
      check("t5_ena_valid", 32'(bus.byte_valid), 32'd1);
      check("t5_ena_byte",  32'(bus.byte_out), 32'h3C);
      check("t5_ena_cnt",   32'(corrected_cnt), 32'(exp_cnt));
      bus.byte_ready = 1'b0;
      sync_clr       = 1'b0;
      ena            = 1'b1;
      strobe(enc(4'h9));
      idle(1);
      expect_byte("t5_ena_b3c", 8'h3C);
      expect_byte("t5_ena_b97", 8'h97);
      check("t5_ena_empty", 32'(bus.byte_valid), 32'd0);

      // 6: counter saturation
      bus.byte_ready = 1'b1;
      for (int i = 0; i < 300; i++) strobe(7'h3D);
      idle(3);
      bus.byte_ready = 1'b0;
      check("t6_sat", 32'(corrected_cnt), 32'd255);
      check("t6_sat_empty", 32'(bus.byte_valid), 32'd0);
      strobe(7'h3D);
      strobe(7'h52);
      idle(1);
      check("t6_sat_hold", 32'(corrected_cnt), 32'd255);
      expect_byte("t6_sat_byte", 8'hA5);

      // 6b: async reset mid-frame
      send_byte(8'h11);
      send_byte(8'h22);
      strobe(enc(4'h3));
      idle(2);
      check("t6_pre_phase", 32'(nibble_phase), 32'd1);
      check("t6_pre_byte",  32'(bus.byte_out), 32'h11);
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_rst_byte",  32'(bus.byte_out), 32'h0);
      check("t6_rst_valid", 32'(bus.byte_valid), 32'd0);
      check("t6_rst_cnt",   32'(corrected_cnt), 32'd0);
      check("t6_rst_ovf",   32'(overflow), 32'd0);
      check("t6_rst_phase", 32'(nibble_phase), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      check("t6_post_valid", 32'(bus.byte_valid), 32'd0);
      send_byte(8'h66);
      idle(1);
      expect_byte("t6_post_byte", 8'h66);
      check("t6_post_empty", 32'(bus.byte_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
